// File: rtl/sdf_output_collector.sv
// ---------------------------------------------------------------------------
// sdf_output_collector
//
// Frame collector at the output end of the SDF NTT/INTT pipeline. The last
// stage delivers one coefficient per cycle and cannot be stalled; in NTT mode
// the coefficients arrive in bit-reversed order. Each N-word frame is written
// into one half of a ping-pong buffer. Completed frames are read back in
// natural index order and handed to the host/DMA side over valid/ready,
// through a 2-entry output FIFO.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   in_valid       one coefficient present (last stage finish)
//   in_data        coefficient (last stage stage_out)
//   in_bitrev      sampled on word 0 of a frame, ANDed with BITREV
//   out_valid      output word valid
//   out_ready      consumer accepts when high together with out_valid
//   out_data       coefficient, natural index order
//   out_last       high on index N-1 of a frame
//   overflow       sticky, a word arrived with no writable bank
//   frames_pending number of banks FULL or DRAINING (0..2)
// ---------------------------------------------------------------------------
module sdf_output_collector #(
   parameter int LOGQ   = 32,
   parameter int LOGN   = 10,
   parameter bit BITREV = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [LOGQ-1:0] in_data,
   input  logic            in_bitrev,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGQ-1:0] out_data,
   output logic            out_last,
   output logic            overflow,
   output logic [1:0]      frames_pending
);

   localparam int N = 1 << LOGN;
   localparam logic [LOGN-1:0] LAST_IDX = {LOGN{1'b1}};
   localparam logic [LOGN-1:0] ZERO_IDX = {LOGN{1'b0}};
   localparam logic [LOGN-1:0] ONE_IDX  = {{(LOGN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_t;

   function automatic logic [LOGN-1:0] bit_reverse(input logic [LOGN-1:0] v);
      logic [LOGN-1:0] r;
      r = {LOGN{1'b0}};
      for (int i = 0; i < LOGN; i++) begin
         r[i] = v[LOGN-1-i];
      end
      return r;
   endfunction

   // Buffer storage: bank index is the address MSB.
   logic [LOGQ-1:0] mem_r [0:2*N-1];

   bank_state_t     bank_r     [2];
   bank_state_t     bank_nxt_s [2];
   logic [1:0]      pend_nxt_s;
   logic [1:0]      frames_pending_r;

   // Writer state
   logic            wr_bank_r;
   logic [LOGN-1:0] wr_cnt_r;
   logic            frame_rev_r;
   logic            frame_ok_r;
   logic            overflow_r;

   // Reader state
   rd_state_t       rd_state_r;
   logic            rd_bank_r;
   logic [LOGN-1:0] rd_cnt_r;
   logic            rd_valid_r;
   logic            rd_last_r;
   logic [LOGQ-1:0] rd_data_r;

   // Output FIFO: head register drives the outputs directly
   logic [LOGQ-1:0] head_data_r;
   logic [LOGQ-1:0] tail_data_r;
   logic            head_last_r;
   logic            tail_last_r;
   logic [1:0]      fifo_cnt_r;
   logic [1:0]      fifo_cnt_nxt_s;
   logic            out_valid_r;

   // Combinational control
   logic            first_s;
   logic            wr_writable_s;
   logic            accept_s;
   logic            drop_s;
   logic            wr_rev_s;
   logic            wr_wrap_s;
   logic [LOGN-1:0] wr_addr_s;
   logic            pop_s;
   logic            push_s;
   logic [2:0]      occ_s;
   logic            space_s;
   logic            rd_go_s;
   logic            issue_s;
   logic            release_s;

   assign out_valid      = out_valid_r;
   assign out_data       = head_data_r;
   assign out_last       = head_last_r;
   assign overflow       = overflow_r;
   assign frames_pending = frames_pending_r;

   // Writer decode: acceptance, drop and write address of the current word
   always_comb begin
      first_s   = (wr_cnt_r == ZERO_IDX);
      wr_wrap_s = in_valid & (wr_cnt_r == LAST_IDX);
      // A bank being released on this edge is already writable: its last read
      // is issued on this same edge and never touches address 0.
      wr_writable_s = (bank_r[wr_bank_r] == BANK_EMPTY) |
                      (release_s & (rd_bank_r == wr_bank_r));
      // The whole frame is accepted or dropped based on its first word, so a
      // bank freed mid-frame never receives a partial frame.
      if (first_s) begin
         accept_s = in_valid & wr_writable_s;
         wr_rev_s = in_bitrev & BITREV;
      end else begin
         accept_s = in_valid & frame_ok_r;
         wr_rev_s = frame_rev_r;
      end
      drop_s = in_valid & ~accept_s;
      if (wr_rev_s) begin
         wr_addr_s = bit_reverse(wr_cnt_r);
      end else begin
         wr_addr_s = wr_cnt_r;
      end
   end

   // Reader decode: FIFO headroom counting the word about to be popped
   always_comb begin
      pop_s   = out_valid_r & out_ready;
      push_s  = rd_valid_r;
      occ_s   = {1'b0, fifo_cnt_r} + {2'b00, rd_valid_r} - {2'b00, pop_s};
      space_s = (occ_s < 3'd2);
      fifo_cnt_nxt_s = fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
      case (rd_state_r)
         RD_IDLE:  rd_go_s = (bank_r[rd_bank_r] == BANK_FULL);
         RD_DRAIN: rd_go_s = 1'b1;
         default:  rd_go_s = 1'b0;
      endcase
      issue_s   = rd_go_s & space_s;
      release_s = issue_s & (rd_cnt_r == LAST_IDX);
   end

   // Bank next-state; writer updates win over reader updates on the same bank
   always_comb begin
      pend_nxt_s = 2'd0;
      for (int i = 0; i < 2; i++) begin
         if (accept_s && (wr_bank_r == 1'(i))) begin
            bank_nxt_s[i] = wr_wrap_s ? BANK_FULL : BANK_FILLING;
         end else if ((rd_state_r == RD_IDLE) && (rd_bank_r == 1'(i)) &&
                      (bank_r[i] == BANK_FULL)) begin
            bank_nxt_s[i] = BANK_DRAINING;
         end else if (release_s && (rd_bank_r == 1'(i))) begin
            bank_nxt_s[i] = BANK_EMPTY;
         end else if (release_s && (rd_bank_r != 1'(i)) &&
                      (bank_r[i] == BANK_FULL)) begin
            bank_nxt_s[i] = BANK_DRAINING;
         end else begin
            bank_nxt_s[i] = bank_r[i];
         end
      end
      for (int i = 0; i < 2; i++) begin
         if ((bank_nxt_s[i] == BANK_FULL) || (bank_nxt_s[i] == BANK_DRAINING)) begin
            pend_nxt_s = pend_nxt_s + 2'd1;
         end else begin
            pend_nxt_s = pend_nxt_s;
         end
      end
   end

   // Bank state registers and pending-frame count
   always_ff @(posedge clk) begin
      if (!rst) begin
         bank_r[0]        <= BANK_EMPTY;
         bank_r[1]        <= BANK_EMPTY;
         frames_pending_r <= 2'd0;
      end else begin
         bank_r[0]        <= bank_nxt_s[0];
         bank_r[1]        <= bank_nxt_s[1];
         frames_pending_r <= pend_nxt_s;
      end
   end

   // Buffer write port (RAM, no reset)
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[{wr_bank_r, wr_addr_s}] <= in_data;
      end
   end

   // Writer counters, frame attributes and sticky overflow
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_bank_r   <= 1'b0;
         wr_cnt_r    <= ZERO_IDX;
         frame_rev_r <= 1'b0;
         frame_ok_r  <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         if (in_valid) begin
            // Count advances even for dropped words to keep frame alignment.
            wr_cnt_r <= wr_cnt_r + ONE_IDX;
            if (first_s) begin
               frame_rev_r <= in_bitrev & BITREV;
               frame_ok_r  <= accept_s;
            end
         end
         // A dropped frame keeps wr_bank so banks still fill in the order the
         // reader drains them.
         if (wr_wrap_s && accept_s) begin
            wr_bank_r <= ~wr_bank_r;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Reader FSM: IDLE waits for the oldest bank to fill, DRAIN issues reads
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_state_r <= RD_IDLE;
         rd_bank_r  <= 1'b0;
         rd_cnt_r   <= ZERO_IDX;
      end else begin
         if (issue_s) begin
            rd_cnt_r <= rd_cnt_r + ONE_IDX;
         end
         case (rd_state_r)
            RD_IDLE: begin
               // Address 0 is read on the same edge the bank is selected.
               if (bank_r[rd_bank_r] == BANK_FULL) begin
                  rd_state_r <= RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               if (release_s) begin
                  rd_bank_r <= ~rd_bank_r;
                  if (bank_r[~rd_bank_r] == BANK_FULL) begin
                     rd_state_r <= RD_DRAIN;
                  end else begin
                     rd_state_r <= RD_IDLE;
                  end
               end
            end
            default: rd_state_r <= RD_IDLE;
         endcase
      end
   end

   // Buffer read port, one cycle latency
   always_ff @(posedge clk) begin
      if (issue_s) begin
         rd_data_r <= mem_r[{rd_bank_r, rd_cnt_r}];
      end
   end

   // Read-in-flight flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_valid_r <= 1'b0;
         rd_last_r  <= 1'b0;
      end else begin
         rd_valid_r <= issue_s;
         rd_last_r  <= release_s;
      end
   end

   // Two-entry output FIFO built as head/tail registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_data_r <= {LOGQ{1'b0}};
         tail_data_r <= {LOGQ{1'b0}};
         head_last_r <= 1'b0;
         tail_last_r <= 1'b0;
         fifo_cnt_r  <= 2'd0;
         out_valid_r <= 1'b0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (fifo_cnt_r == 2'd0) begin
                  head_data_r <= rd_data_r;
                  head_last_r <= rd_last_r;
               end else begin
                  tail_data_r <= rd_data_r;
                  tail_last_r <= rd_last_r;
               end
            end
            2'b01: begin
               head_data_r <= tail_data_r;
               head_last_r <= tail_last_r;
            end
            2'b11: begin
               if (fifo_cnt_r == 2'd1) begin
                  head_data_r <= rd_data_r;
                  head_last_r <= rd_last_r;
               end else begin
                  head_data_r <= tail_data_r;
                  head_last_r <= tail_last_r;
                  tail_data_r <= rd_data_r;
                  tail_last_r <= rd_last_r;
               end
            end
            default: begin
               head_data_r <= head_data_r;
            end
         endcase
         fifo_cnt_r  <= fifo_cnt_nxt_s;
         out_valid_r <= (fifo_cnt_nxt_s != 2'd0);
      end
   end

endmodule

// File: tb/tb_sdf_output_collector.sv
module tb_sdf_output_collector;

   localparam int LOGQ = 32;
   localparam int LOGN = 4;
   localparam int NW   = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [LOGQ-1:0] in_data;
   logic            in_bitrev;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [LOGQ-1:0] out_data;
   logic            out_last;
   logic            overflow;
   logic [1:0]      frames_pending;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int fp_max = 0;

   logic [32:0] exp_q [$];
   int          pop_cyc_q [$];

   logic        rand_mode = 1'b0;
   logic        ready_fix = 1'b1;
   logic        stall_seen = 1'b0;
   logic [31:0] held_data;
   logic        held_last;

   // Natural output index j holds input word brev_tab[j] of a bit-reversed frame.
   int brev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   sdf_output_collector #(.LOGQ(LOGQ), .LOGN(LOGN), .BITREV(1'b1)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_bitrev      (in_bitrev),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .overflow       (overflow),
      .frames_pending (frames_pending)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer ready: fixed level or 50% random
   always @(posedge clk) begin
      #2;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stall stability
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
               check("hold_data", out_data, held_data);
               check("hold_last", 32'(out_last), 32'(held_last));
            end
         end
         if (out_valid && out_ready) begin
            stall_seen = 1'b0;
            pop_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual=%0d required=none", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e[31:0]);
               check("out_last", 32'(out_last), 32'(e[32]));
            end
         end else if (out_valid) begin
            stall_seen = 1'b1;
            held_data  = out_data;
            held_last  = out_last;
         end else begin
            stall_seen = 1'b0;
         end
         if (int'(frames_pending) > fp_max) fp_max = int'(frames_pending);
      end
   end

   task automatic push_frame(input int base, input logic rev);
      for (int j = 0; j < NW; j++) begin
         exp_q.push_back({(j == NW - 1) ? 1'b1 : 1'b0,
                          32'(rev ? base + brev_tab[j] : base + j)});
      end
   endtask

   task automatic send_words(input int base, input logic rev, input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         in_valid  = 1'b1;
         in_data   = 32'(base + k);
         in_bitrev = rev;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d words left required=0", exp_q.size());
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_last"}, 32'(out_last), 32'd0);
      check({tag, "_out_data"}, out_data, 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_frames_pending"}, 32'(frames_pending), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nb;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      in_bitrev = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst0");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Bit-reversed frame, latency of the first output
      push_frame(0, 1'b1);
      send_words(0, 1'b1, 0, NW - 1);
      @(negedge clk);
      check("lat_t0", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_t1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_t2", 32'(out_valid), 32'd1);
      wait_empty();

      // Natural-order frame
      push_frame(100, 1'b0);
      send_words(100, 1'b0, 0, NW - 1);
      wait_empty();

      // Three back-to-back frames, full throughput
      nb = pop_cyc_q.size();
      push_frame(200, 1'b0);
      push_frame(300, 1'b1);
      push_frame(500, 1'b0);
      send_words(200, 1'b0, 0, NW - 1);
      send_words(300, 1'b1, 0, NW - 1);
      send_words(500, 1'b0, 0, NW - 1);
      wait_empty();
      check("b2b_count", 32'(pop_cyc_q.size() - nb), 32'd48);
      if (pop_cyc_q.size() - nb == 48) begin
         check("b2b_no_gap", 32'(pop_cyc_q[nb + 47] - pop_cyc_q[nb]), 32'd47);
      end
      check("b2b_overflow", 32'(overflow), 32'd0);
      check("fp_max_le2", 32'(fp_max <= 2), 32'd1);

      // Consumer stalled: frame 3 overflows and is lost
      ready_fix = 1'b0;
      @(posedge clk);
      #1;
      push_frame(600, 1'b0);
      push_frame(700, 1'b1);
      send_words(600, 1'b0, 0, NW - 1);
      send_words(700, 1'b1, 0, NW - 1);
      check("stall_pending2", 32'(frames_pending), 32'd2);
      check("stall_no_ovf_yet", 32'(overflow), 32'd0);
      send_words(800, 1'b0, 0, 0);
      check("stall_ovf_word0", 32'(overflow), 32'd1);
      send_words(800, 1'b0, 1, NW - 1);
      check("stall_pending_hold", 32'(frames_pending), 32'd2);
      check("stall_buffered", 32'(out_valid), 32'd1);
      ready_fix = 1'b1;
      wait_empty();

      // Random backpressure over two frames
      rand_mode = 1'b1;
      push_frame(900, 1'b1);
      push_frame(1000, 1'b0);
      send_words(900, 1'b1, 0, NW - 1);
      send_words(1000, 1'b0, 0, NW - 1);
      wait_empty();
      rand_mode = 1'b0;
      @(posedge clk);
      #1;

      // Reset at word 7 of frame 2, then a fresh frame
      push_frame(1100, 1'b0);
      send_words(1100, 1'b0, 0, NW - 1);
      send_words(1200, 1'b0, 0, 6);
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'd1207;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_reset_outputs("midrst");
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      push_frame(1300, 1'b1);
      send_words(1300, 1'b1, 0, NW - 1);
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
